// File: rtl/arb_requester.sv
// arb_requester: requester-side agent for an eight-way round-robin arbiter.
// Queues burst commands, requests the bus, holds lock while the burst runs,
// and releases lock on the final acknowledged beat so priority can rotate.
// Optional watchdog abort is compiled in with `define ARB_REQ_TIMEOUT_EN.
module arb_requester #(
    parameter int DEPTH   = 4,
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_adr,
    input  logic [2:0]    cmd_len,
    output logic          req,
    input  logic          sel,
    output logic          lock,
    output logic          bus_cyc,
    output logic          bus_stb,
    output logic [AW-1:0] bus_adr,
    input  logic          bus_ack,
    output logic          busy,
    output logic          err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        REL  = 2'd3
    } state_t;

    state_t          state_reg, state_next;

    logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [AW-1:0]   adr_mem [DEPTH];
    logic [2:0]      len_mem [DEPTH];

    logic [AW-1:0]   head_adr;
    logic [2:0]      head_len;
    logic [AW-1:0]   bus_adr_reg;
    logic [2:0]      beat_reg;

    logic            push;
    logic            pop;
    logic            last_ack;
    logic            abort;
    logic            grant_taken;
    logic            in_xfer;
    logic            count_nz;

    // FIFO flow control is based on the registered count only, so a full
    // FIFO never accepts a push in the same cycle as a pop.
    assign cmd_ready   = (count_reg < CW'(DEPTH));
    assign push        = cmd_valid & cmd_ready;
    assign count_nz    = (count_reg != '0);
    assign in_xfer     = (state_reg == XFER);
    assign last_ack    = in_xfer & bus_ack & (beat_reg == 3'd0);
    assign pop         = last_ack | abort;
    assign grant_taken = (state_reg == REQ) & sel;
    assign head_adr    = adr_mem[rd_ptr_reg];
    assign head_len    = len_mem[rd_ptr_reg];

    // Command storage: written on push, no reset needed since pointers guard it.
    always_ff @(posedge clk) begin
        if (push) begin
            adr_mem[wr_ptr_reg] <= cmd_adr;
            len_mem[wr_ptr_reg] <= cmd_len;
        end
    end

    // FIFO pointers and occupancy; reset discards any queued commands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; REL waits for a ce cycle so the arbiter has
    // re-registered sel and a stale grant is never reused.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (count_nz) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (sel) begin
                    state_next = XFER;
                end
            end
            XFER: begin
                if (pop) begin
                    state_next = REL;
                end
            end
            REL: begin
                if (ce) begin
                    state_next = count_nz ? REQ : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Beat address and remaining-beat counter: loaded on grant, stepped per ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_adr_reg <= '0;
            beat_reg    <= '0;
        end else if (grant_taken) begin
            bus_adr_reg <= head_adr;
            beat_reg    <= head_len;
        end else if (in_xfer && bus_ack) begin
            bus_adr_reg <= bus_adr_reg + AW'(1);
            beat_reg    <= beat_reg - 3'd1;
        end
    end

`ifdef ARB_REQ_TIMEOUT_EN
    // Watchdog: the abort fires in the stalled cycle whose increment would
    // reach TIMEOUT, so err/lock/bus_cyc change in that same cycle.
    localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] wd_reg;
    logic       err_reg;

    assign abort = in_xfer & ~bus_ack & (wd_reg == WD_LIMIT);
    assign err   = err_reg | abort;

    // Stall counter: cleared on XFER entry and on every ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_reg <= '0;
        end else if (grant_taken) begin
            wd_reg <= '0;
        end else if (in_xfer) begin
            wd_reg <= bus_ack ? 8'd0 : wd_reg + 8'd1;
        end
    end

    // Sticky abort flag; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_reg <= 1'b0;
        end else if (abort) begin
            err_reg <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign abort          = 1'b0;
    assign err            = 1'b0;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    // Outputs decode straight from state so reset drops them immediately.
    always_comb begin
        req     = (state_reg == REQ) | in_xfer | ((state_reg == REL) & count_nz);
        bus_cyc = in_xfer & ~abort;
        bus_stb = in_xfer & ~abort;
        lock    = sel & ((state_reg == REQ) | (in_xfer & ~last_ack & ~abort));
        busy    = (state_reg != IDLE);
        bus_adr = bus_adr_reg;
    end

endmodule

// File: doc/arb_requester.md
# arb_requester

Requester-side agent for the eight-way round-robin grant arbiter. Queues burst commands in a small FIFO, raises `req`, waits for its one-hot `sel` bit, then holds `lock` and runs a multi-beat address burst on the shared bus. It releases `lock` on the last acknowledged beat so the arbiter can rotate priority. One instance sits on each of the arbiter's request lines.

## Interface
- `DEPTH`, 4 — command FIFO entries (power of two, 2..16)
- `AW`, 32 — bus address width
- `TIMEOUT`, 255 — watchdog limit in cycles (used only when the watchdog is compiled in)
- `clk` in 1 — clock; one clock domain
- `rst` in 1 — reset, asynchronous and active-low; all state clears while `rst`=0
- `ce` in 1 — same clock enable that drives the arbiter
- `cmd_valid` in 1 — command offered
- `cmd_ready` out 1 — FIFO can accept
- `cmd_adr` in AW — burst start address
- `cmd_len` in 3 — beats minus one (0 = 1 beat, 7 = 8 beats)
- `req` out 1 — request to arbiter
- `sel` in 1 — this requester's bit of the arbiter's registered `sel`
- `lock` out 1 — to arbiter's `lock` bit for this requester
- `bus_cyc`, `bus_stb` out 1 — bus cycle and strobe
- `bus_adr` out AW — beat address
- `bus_ack` in 1 — beat acknowledge
- `busy` out 1 — state ≠ IDLE
- `err` out 1 — sticky watchdog abort flag

## Operation
- FIFO:
  - Push when `cmd_valid & cmd_ready`; pop on the last acked beat.
  - `cmd_ready` = count < DEPTH and is registered-count based. When full, no push happens in the same cycle as a pop.
  - Simultaneous push and pop leaves count unchanged.
- States: IDLE, REQ, XFER, REL.
  - **IDLE:** `req`=0. Go to REQ when count ≠ 0.
  - **REQ:** `req`=1. When `sel`=1, load `bus_adr`=head.adr and the beat counter = head.len, then go to XFER.
  - **XFER:**
    - `bus_cyc`=`bus_stb`=1, `req`=1.
    - Each `bus_ack` increments `bus_adr` by 1 (wraps modulo 2^AW) and decrements the counter.
    - An ack with counter=0 pops the FIFO, drops `bus_cyc`/`bus_stb`, and goes to REL.
  - **REL:**
    - `req` = (count after pop ≠ 0).
    - Stay until a cycle with `ce`=1, so the arbiter has re-evaluated. Then go to REQ if count ≠ 0, else IDLE.
    - `sel` is ignored in REL.
- `lock` (combinational) = `sel` & ((state=REQ) | (state=XFER & ~(bus_ack & counter=0))). Lock is therefore asserted in the same cycle `sel` is first seen, and deasserted in the same cycle as the final ack.
- `bus_ack` outside XFER is ignored.
- Reset mid-burst: all outputs drop immediately. The FIFO empties and any in-flight burst is discarded without a pop side effect.

## Timing
- Reset values: `req`=0, `lock`=0, `bus_cyc`=0, `bus_stb`=0, `bus_adr`=0, `busy`=0, `err`=0, `cmd_ready`=1.
- Push to `req`: the command is written at edge N; `req`=1 from cycle N+2 (IDLE→REQ registered).
- The arbiter registers `sel` on a `ce` edge. `bus_cyc` rises one cycle after `sel` is first high.
- Beat throughput: one beat per cycle while `bus_ack` is held high. An n-beat burst with continuous ack occupies XFER for n cycles.
- Minimum gap between back-to-back bursts from the same requester: one REL cycle, plus any wait for `ce`, plus one REQ cycle.

## Configuration
- Macro: `ARB_REQ_TIMEOUT_EN`.
- **Defined:**
  - An 8-bit counter clears on every `bus_ack` and on XFER entry, and increments each XFER cycle without ack.
  - When it reaches TIMEOUT: abort the burst, pop the entry, set `err`=1, deassert `lock`/`bus_cyc`/`bus_stb` that cycle, and go to REL.
  - `err` clears only on reset.
- **Undefined:** no counter; XFER waits forever for ack; `err` is tied to 0.

## Test plan
- Reset and idle: hold `rst`=0 for 3 cycles, then release with no commands → all outputs at reset values, `cmd_ready`=1, state IDLE for 20 cycles.
- Single burst: push adr=0x100, len=3; drive `sel`=1 two cycles after `req`; hold `bus_ack`=1 → `bus_adr` = 0x100..0x103 on 4 consecutive cycles. `lock`=1 from the `sel` cycle until the 4th ack cycle, where it drops. `busy`=0 after REL with `ce`=1.
- FIFO full and back-to-back: push 5 commands with DEPTH=4 → the 5th is stalled (`cmd_ready`=0) until the first burst's final ack. Bursts run in push order with REL between each.
- Grant latency and ce gating: `ce`=1 every 4th cycle and `sel` held high after the final ack → the requester stays in REL until the `ce` cycle and does not restart on the stale `sel`.
- Address wrap and stalled acks: AW=8, adr=0xFE, len=3, ack every other cycle → addresses 0xFE, 0xFF, 0x00, 0x01; `lock` stays high through the gaps.
- With `ARB_REQ_TIMEOUT_EN`, TIMEOUT=10, no ack → on the 10th stalled cycle `err`=1, `bus_cyc`=0, `lock`=0, and the entry is popped. Reset mid-XFER → outputs drop asynchronously and `err`=0.
